cma_tap_sched: RTL and testbench
================================

# cma_tap_sched

Sequencer that runs one CMA coefficient update across all NTAPS equalizer taps using a single shared single-tap update datapath (cma_base), one tap per clock. It holds the coefficient register bank and sits between the FIR/error path, which supplies y, error and the delay-line snapshot, and the FIR, which reads coefficients. Operands are captured at start, so the FIR may keep running during the sweep.

## Interface
- NTAPS, 9: number of taps (≥2)
- NB_I, 18: width of x[k] and y
- NBF_I, 15: fractional bits of x[k] and y
- NB, 8: coefficient and error width
- NBF, 7: coefficient and error fractional bits
- NB_MU, 16: mu width, signed, NB_MU-1 fractional bits

- i_clk  in  1  clock; all state changes on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_start  in  1  request one update sweep, pulse
- i_init  in  1  reload the initial coefficient set, pulse
- i_fir_out  in  NB_I  y, sampled at accepted start
- i_error  in  NB  CMA error, sampled at accepted start
- i_mu  in  NB_MU  step size, sampled at accepted start
- i_x_flat  in  NTAPS*NB_I  delay line; x[k] = [k*NB_I +: NB_I]; sampled at accepted start
- o_w_flat  out  NTAPS*NB  coefficient bank; w[k] = [k*NB +: NB]
- o_busy  out  1  sweep in progress
- o_done  out  1  one-cycle pulse after the last tap is written
- o_tap_idx  out  clog2(NTAPS)  tap being updated while busy, else 0

## Operation
- Initial set: w[NTAPS/2] = 2^(NBF-1), which is 0.5, or 64 for NB=8/NBF=7. All other taps are 0.
- States:
  - IDLE: o_busy=0. i_start=1 captures y, e, mu and every x[k] into snapshot registers, clears the index and moves to UPDATE.
  - UPDATE: o_busy=1. The shared datapath computes w_new = sat(w[idx] − mu·e·y·x[idx]) at full precision, truncates to NB/NBF and saturates to [−2^(NB−1), 2^(NB−1)−1]. Write-back to w[idx] happens at the clock edge. If idx = NTAPS−1, go to DONE; otherwise idx increments.
  - DONE: o_done=1 for one cycle, o_busy=0, then IDLE. i_start in DONE is ignored.
- i_start while o_busy=1 or in DONE: ignored, not queued.
- i_init in any state: loads the initial set and forces IDLE. Any sweep in progress is aborted with no o_done and no further writes. If i_init and i_start are both high in IDLE, i_init wins and the start is dropped.
- Only w[idx] changes in a given cycle. All other taps hold.
- The snapshot registers are the only operand source during a sweep. Live input changes during UPDATE have no effect.

## Timing
- Reset (async, immediate):
  - state IDLE
  - o_busy=0, o_done=0, o_tap_idx=0
  - o_w_flat = initial set
  - snapshot registers 0
- Start sampled at edge t:
  - o_busy=1 during cycles t+1 … t+NTAPS.
  - w[k] is updated at edge t+1+k.
  - o_done=1 during cycle t+NTAPS+1.
  - The next start is accepted at edge t+NTAPS+2 at the earliest.
- Sweep period: NTAPS+2 cycles. Start-to-done latency: NTAPS+1 cycles.
- o_w_flat is registered. A write at edge n is visible in the cycle after edge n.
- Reset asserted mid-sweep: outputs go to their reset values immediately. Partially updated taps are discarded.

## Test plan
- Reset then idle: after release, o_w_flat = 64 at tap 4 and 0 elsewhere (NTAPS=9), o_busy=0, o_done=0. Hold for 20 cycles with no start: no change.
- Nominal sweep: all x[k]=16384 (0.5), y=16384, e=64 (0.5), mu=16384 (0.5); start at edge t.
  - Tap 4: 64→56.
  - Other taps: 0→−8.
  - w[k] changes at edge t+1+k.
  - o_done is high only in cycle t+10.
  - o_busy is high for exactly 9 cycles.
- Saturation and mu=0: preload via sweeps so w[0]=127, then sweep with y=−32768, e=−128, mu=32767, x[0]=−32768. w[0] stays 127 (no wrap). A sweep with mu=0 leaves every tap bit-identical.
- Snapshot isolation / start while busy: change y, e, mu and x every cycle during UPDATE and pulse i_start mid-sweep. Results match the start-time values, and exactly one o_done is produced.
- Init abort and priority: pulse i_init at sweep cycle 4. The bank returns to the initial set on the next cycle, no o_done, state IDLE. i_init and i_start together in IDLE: initial set loaded, o_busy stays 0.
- Async reset mid-sweep: drop i_rst_n between edges in cycle 5. o_busy, o_done and o_tap_idx fall immediately with no clock edge, and the bank equals the initial set.

Source files
------------

// File: rtl/cma_tap_sched.sv
// cma_tap_sched: sweeps one CMA coefficient update over all taps through a shared single-tap datapath.
module cma_tap_sched #(
  parameter int NTAPS = 9,
  parameter int NB_I  = 18,
  parameter int NBF_I = 15,
  parameter int NB    = 8,
  parameter int NBF   = 7,
  parameter int NB_MU = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_init,
  input  logic signed [NB_I-1:0]        i_fir_out,
  input  logic signed [NB-1:0]          i_error,
  input  logic signed [NB_MU-1:0]       i_mu,
  input  logic [NTAPS*NB_I-1:0]         i_x_flat,
  output logic [NTAPS*NB-1:0]           o_w_flat,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(NTAPS)-1:0]      o_tap_idx
);
  localparam int IW = $clog2(NTAPS);
  localparam int PW = NB_MU + NB + 2*NB_I;
  localparam int SH = NB_MU - 1 + 2*NBF_I;
  localparam int DW = PW - SH + 1;
  localparam logic [IW-1:0] LAST = IW'(NTAPS-1);
  localparam logic signed [NB-1:0] W_INIT = NB'(2**(NBF-1));
  localparam logic signed [DW-1:0] WMAX = DW'(2**(NB-1)-1);
  localparam logic signed [DW-1:0] WMIN = ~WMAX;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic signed [NB-1:0] r_w [NTAPS];
  logic signed [NB_I-1:0] r_y, r_x [NTAPS];
  logic signed [NB-1:0] r_e;
  logic signed [NB_MU-1:0] r_mu;
  logic w_acc;
  logic signed [NB-1:0] w_cur, w_new;
  logic signed [PW-1:0] w_p;
  logic signed [DW-2:0] w_pt;
  logic signed [DW-1:0] w_d;

  assign w_acc = (r_state == IDLE) && i_start && !i_init;
  assign w_cur = r_w[r_idx];
  // mu*e*y*x carries SH fractional bits beyond NBF; dropping them floors the step
  assign w_p   = PW'(r_mu) * PW'(r_e) * PW'(r_y) * PW'(r_x[r_idx]);
  assign w_pt  = w_p[PW-1:SH];
  assign w_d   = DW'(w_cur) - DW'(w_pt);
  assign w_new = (w_d > WMAX) ? WMAX[NB-1:0] : (w_d < WMIN) ? WMIN[NB-1:0] : w_d[NB-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (i_init) w_next = IDLE;
    else if (w_acc) w_next = UPDATE;
    else if (r_state == UPDATE && r_idx == LAST) w_next = DONE;
    else if (r_state == DONE) w_next = IDLE;
  end

  always_comb begin
    o_busy    = r_state == UPDATE;
    o_done    = r_state == DONE;
    o_tap_idx = o_busy ? r_idx : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_idx <= '0;
      r_y   <= '0;
      r_e   <= '0;
      r_mu  <= '0;
      for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
    end else if (w_acc) begin
      r_idx <= '0;
      r_y   <= i_fir_out;
      r_e   <= i_error;
      r_mu  <= i_mu;
      for (int k = 0; k < NTAPS; k++) r_x[k] <= i_x_flat[k*NB_I +: NB_I];
    end else if (r_state == UPDATE) r_idx <= r_idx + IW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n || i_init) begin
      for (int k = 0; k < NTAPS; k++) r_w[k] <= (k == NTAPS/2) ? W_INIT : '0;
    end else if (r_state == UPDATE) r_w[r_idx] <= w_new;

  for (genvar k = 0; k < NTAPS; k++) begin : g_w
    assign o_w_flat[k*NB +: NB] = r_w[k];
  end
endmodule

// File: tb/tb_cma_tap_sched.sv
// tb_cma_tap_sched: directed table-driven bench for the CMA tap update sequencer.
module tb_cma_tap_sched;
  localparam int N = 9, NBI = 18, NB = 8;
  logic clk = 0, rst_n = 0, start = 0, init = 0;
  logic [NBI-1:0] y = '0;
  logic [NB-1:0] e = '0;
  logic [15:0] mu = '0;
  logic [N*NBI-1:0] x = '0;
  logic [N*NB-1:0] w;
  logic busy, done;
  logic [3:0] idx;
  int pass = 0, total = 0, nd;

  typedef struct {logic start; logic busy; logic done; logic [3:0] idx; int n;} vec_t;
  vec_t tv[12];

  cma_tap_sched dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_init(init),
    .i_fir_out(y), .i_error(e), .i_mu(mu), .i_x_flat(x),
    .o_w_flat(w), .o_busy(busy), .o_done(done), .o_tap_idx(idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] ex);
    total++;
    if (a === ex) pass++;
    else $display("FAIL %s: got %h want %h", nm, a, ex);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*NB-1:0] mk(input int w0, input int w4, input int wo);
    logic [N*NB-1:0] r;
    for (int k = 0; k < N; k++) r[k*NB +: NB] = 8'(k == 0 ? w0 : k == 4 ? w4 : wo);
    return r;
  endfunction

  // nominal sweep with the first n taps already written
  function automatic logic [N*NB-1:0] nom(input int n);
    logic [N*NB-1:0] r;
    for (int k = 0; k < N; k++) r[k*NB +: NB] = 8'(k < n ? (k == 4 ? 56 : -8) : (k == 4 ? 64 : 0));
    return r;
  endfunction

  task automatic setall(input int xv, input int yv, input int ev, input int mv);
    x  = {N{18'(xv)}};
    y  = 18'(yv);
    e  = 8'(ev);
    mu = 16'(mv);
  endtask

  task automatic sweep(input string nm);
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 20 && !done; i++) tick;
    chk({nm, "_done"}, 128'(done), 128'(1));
    tick;
  endtask

  task automatic pulse_init;
    init = 1;
    tick;
    init = 0;
  endtask

  initial begin
    tv[0] = '{1, 1, 0, 0, 0};
    for (int i = 1; i < 9; i++) tv[i] = '{i == 4, 1, 0, 4'(i), i};
    tv[9]  = '{0, 0, 1, 0, 9};
    tv[10] = '{1, 0, 0, 0, 9};
    tv[11] = '{0, 0, 0, 0, 9};

    #12;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_idx", 128'(idx), 128'(0));
    chk("rst_bank", 128'(w), 128'(mk(0, 64, 0)));
    @(negedge clk) rst_n = 1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (busy || done) nd++;
    end
    chk("idle_quiet", 128'(nd), 128'(0));
    chk("idle_bank", 128'(w), 128'(mk(0, 64, 0)));

    setall(16384, 16384, 64, 16384);
    for (int i = 0; i < 12; i++) begin
      start = tv[i].start;
      tick;
      chk($sformatf("nom%0d_busy", i), 128'(busy), 128'(tv[i].busy));
      chk($sformatf("nom%0d_done", i), 128'(done), 128'(tv[i].done));
      chk($sformatf("nom%0d_idx", i), 128'(idx), 128'(tv[i].idx));
      chk($sformatf("nom%0d_bank", i), 128'(w), 128'(nom(tv[i].n)));
    end
    start = 0;

    pulse_init;
    chk("init_bank", 128'(w), 128'(mk(0, 64, 0)));
    setall(0, -32768, -128, 32767);
    x[17:0] = 18'(-32768);
    sweep("sat1");
    chk("sat1_bank", 128'(w), 128'(mk(127, 64, 0)));
    sweep("sat2");
    chk("sat2_bank", 128'(w), 128'(mk(127, 64, 0)));
    for (int k = 0; k < N; k++) x[k*NBI +: NBI] = 18'($urandom);
    y = 18'($urandom);
    e = 8'($urandom);
    mu = '0;
    sweep("mu0");
    chk("mu0_bank", 128'(w), 128'(mk(127, 64, 0)));

    pulse_init;
    setall(16384, 16384, 64, 16384);
    start = 1;
    tick;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < N; k++) x[k*NBI +: NBI] = 18'($urandom);
      y = 18'($urandom);
      e = 8'($urandom);
      mu = 16'($urandom);
      start = (i == 3);
      if (done) begin
        nd++;
        start = 1;
      end
      tick;
    end
    start = 0;
    chk("iso_ndone", 128'(nd), 128'(1));
    chk("iso_bank", 128'(w), 128'(nom(9)));
    chk("iso_idle", 128'(busy), 128'(0));

    pulse_init;
    setall(16384, 16384, 64, 16384);
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 20 && idx != 3; i++) tick;
    chk("abort_pre_idx", 128'(idx), 128'(3));
    chk("abort_pre_bank", 128'(w), 128'(nom(3)));
    pulse_init;
    chk("abort_bank", 128'(w), 128'(mk(0, 64, 0)));
    chk("abort_busy", 128'(busy), 128'(0));
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) nd++;
      tick;
    end
    chk("abort_nodone", 128'(nd), 128'(0));
    chk("abort_hold", 128'(w), 128'(mk(0, 64, 0)));
    init = 1;
    start = 1;
    tick;
    init = 0;
    start = 0;
    chk("prio_busy", 128'(busy), 128'(0));
    chk("prio_bank", 128'(w), 128'(mk(0, 64, 0)));
    tick;
    chk("prio_busy2", 128'(busy), 128'(0));

    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 4; i++) tick;
    chk("arst_pre_busy", 128'(busy), 128'(1));
    chk("arst_pre_idx", 128'(idx), 128'(4));
    #2 rst_n = 0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    chk("arst_idx", 128'(idx), 128'(0));
    chk("arst_bank", 128'(w), 128'(mk(0, 64, 0)));
    @(negedge clk) rst_n = 1;
    tick;
    chk("arst_after", 128'(busy), 128'(0));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
